// File: rtl/aes_spi_link_slave_if.sv
// Serial link and core handshake bundle between an SPI master/AES core pair
// and the link slave.
interface aes_spi_link_slave_if;
   logic         cs;
   logic         sdi;
   logic         sdo;
   logic [1:0]   nk_val;
   logic         core_start;
   logic [127:0] core_data;
   logic [255:0] core_key;
   logic [1:0]   core_nk;
   logic         core_done;
   logic [127:0] core_result;
   logic         busy;
   logic         frame_done;
   logic         err_late;

   modport slave (
      input  cs, sdi, nk_val, core_done, core_result,
      output sdo, core_start, core_data, core_key, core_nk, busy, frame_done, err_late
   );

   modport master (
      output cs, sdi, nk_val, core_done, core_result,
      input  sdo, core_start, core_data, core_key, core_nk, busy, frame_done, err_late
   );
endinterface

// File: rtl/aes_spi_link_slave.sv
// Slave side of the AES serial link: receives block+key frames, runs the core
// handshake and shifts the 128-bit result back after a fixed gap.
module aes_spi_link_slave #(
   parameter int GAP_BITS = 4
) (
   input logic clk,
   input logic rst,
   aes_spi_link_slave_if.slave io_link
);
   localparam int DATA_W = 128;
   localparam int KEY_W  = 256;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RX_DATA = 3'd1,
      ST_RX_KEY  = 3'd2,
      ST_GAP     = 3'd3,
      ST_TX      = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   state_t              r_state;
   logic [8:0]          r_rx_cnt;
   logic [7:0]          r_gap_cnt;
   logic [6:0]          r_tx_cnt;
   logic                r_sdo;
   logic                r_core_start;
   logic [DATA_W-1:0]   r_core_data;
   logic [KEY_W-1:0]    r_core_key;
   logic [1:0]          r_core_nk;
   logic                r_busy;
   logic                r_frame_done;
   logic                r_err_late;
   logic [DATA_W-1:0]   r_res;
   logic                r_res_valid;
   logic                r_res_wait;
   logic [DATA_W-1:0]   r_tx_sh;

   logic w_abort;
   logic w_capture;

   assign w_abort   = (r_state != ST_IDLE) && io_link.cs;
   assign w_capture = r_res_wait && io_link.core_done && !w_abort;

   // Frame FSM, result latch and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_rx_cnt     <= 9'd0;
         r_gap_cnt    <= 8'd0;
         r_tx_cnt     <= 7'd0;
         r_sdo        <= 1'b0;
         r_core_start <= 1'b0;
         r_core_data  <= '0;
         r_core_key   <= '0;
         r_core_nk    <= 2'b00;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_err_late   <= 1'b0;
         r_res        <= '0;
         r_res_valid  <= 1'b0;
         r_res_wait   <= 1'b0;
         r_tx_sh      <= '0;
      end else begin
         r_core_start <= 1'b0;
         r_frame_done <= 1'b0;
         // Only the first core_done after our own core_start is kept.
         if (w_capture) begin
            r_res       <= io_link.core_result;
            r_res_valid <= 1'b1;
            r_res_wait  <= 1'b0;
         end
         if (w_abort) begin
            r_state    <= ST_IDLE;
            r_rx_cnt   <= 9'd0;
            r_gap_cnt  <= 8'd0;
            r_tx_cnt   <= 7'd0;
            r_sdo      <= 1'b0;
            r_busy     <= 1'b0;
            r_res_wait <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (!io_link.cs) begin
                     r_core_data <= {r_core_data[DATA_W-2:0], io_link.sdi};
                     r_rx_cnt    <= 9'd1;
                     r_busy      <= 1'b1;
                     r_err_late  <= 1'b0;
                     r_state     <= ST_RX_DATA;
                  end
               end
               ST_RX_DATA: begin
                  r_core_data <= {r_core_data[DATA_W-2:0], io_link.sdi};
                  r_rx_cnt    <= r_rx_cnt + 9'd1;
                  if (r_rx_cnt == 9'd127) begin
                     r_state <= ST_RX_KEY;
                  end
               end
               ST_RX_KEY: begin
                  r_core_key <= {r_core_key[KEY_W-2:0], io_link.sdi};
                  if (r_rx_cnt == 9'd383) begin
                     r_rx_cnt     <= 9'd0;
                     r_core_start <= 1'b1;
                     r_core_nk    <= io_link.nk_val;
                     r_res_valid  <= 1'b0;
                     r_res_wait   <= 1'b1;
                     r_gap_cnt    <= 8'd0;
                     r_state      <= ST_GAP;
                  end else begin
                     r_rx_cnt <= r_rx_cnt + 9'd1;
                  end
               end
               // The core_start cycle is the first GAP cycle, so GAP holds GAP_BITS+1 cycles.
               ST_GAP: begin
                  if (r_gap_cnt == 8'(GAP_BITS)) begin
                     r_gap_cnt <= 8'd0;
                     r_tx_cnt  <= 7'd0;
                     r_state   <= ST_TX;
                     if (r_res_valid) begin
                        r_sdo   <= r_res[DATA_W-1];
                        r_tx_sh <= {r_res[DATA_W-2:0], 1'b0};
                     end else begin
                        r_sdo      <= 1'b0;
                        r_tx_sh    <= '0;
                        r_err_late <= 1'b1;
                     end
                  end else begin
                     r_gap_cnt <= r_gap_cnt + 8'd1;
                  end
               end
               ST_TX: begin
                  if (r_tx_cnt == 7'd127) begin
                     r_tx_cnt     <= 7'd0;
                     r_sdo        <= 1'b0;
                     r_frame_done <= 1'b1;
                     r_state      <= ST_DONE;
                  end else begin
                     r_sdo    <= r_tx_sh[DATA_W-1];
                     r_tx_sh  <= {r_tx_sh[DATA_W-2:0], 1'b0};
                     r_tx_cnt <= r_tx_cnt + 7'd1;
                  end
               end
               // cs is low here (high was taken as abort); next cycle carries bit 0.
               ST_DONE: begin
                  r_rx_cnt   <= 9'd0;
                  r_err_late <= 1'b0;
                  r_state    <= ST_RX_DATA;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_sdo   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign io_link.sdo        = r_sdo;
   assign io_link.core_start = r_core_start;
   assign io_link.core_data  = r_core_data;
   assign io_link.core_key   = r_core_key;
   assign io_link.core_nk    = r_core_nk;
   assign io_link.busy       = r_busy;
   assign io_link.frame_done = r_frame_done;
   assign io_link.err_late   = r_err_late;
endmodule

// File: tb/tb_aes_spi_link_slave.sv
// Directed bench for aes_spi_link_slave using FIPS-197 vectors and a
// fixed-latency core stand-in.
module tb_aes_spi_link_slave;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   int           n_vec = 0;
   int           n_bad = 0;
   int           core_lat = 2;
   int           core_cnt = 0;
   logic [127:0] core_res = '0;
   logic         seen;

   localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes_spi_link_slave_if link();

   aes_spi_link_slave #(.GAP_BITS(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .io_link (link)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Core stand-in: core_done (with core_result) lands core_lat cycles after core_start.
   always @(negedge clk) begin
      link.core_done = 1'b0;
      if (core_cnt > 0) begin
         core_cnt = core_cnt - 1;
         if (core_cnt == 0) begin
            link.core_done   = 1'b1;
            link.core_result = core_res;
         end
      end
      if (link.core_start === 1'b1) core_cnt = core_lat;
   end

   // Cycle n of the frame is the period ending at the edge that samples wire bit n.
   task automatic run_frame(input logic [127:0] blk, input logic [255:0] key, input logic [1:0] nk,
                            input logic [127:0] res, input int lat, input logic exp_late,
                            input logic desel, input int last_n);
      logic [127:0] got;
      got         = '0;
      core_res    = res;
      core_lat    = lat;
      link.nk_val = nk;
      for (int n = 0; n <= last_n; n++) begin
         @(negedge clk);
         link.cs = (n == 517) ? desel : 1'b0;
         if (n < 128)      link.sdi = blk[127-n];
         else if (n < 384) link.sdi = key[383-n];
         else              link.sdi = 1'($urandom);
         if (n == 1) chk("err_late_clear", link.err_late, 1'b0);
         if (n == 384) begin
            chk("core_start", link.core_start, 1'b1);
            chk("core_nk", link.core_nk, nk);
            chk("core_data", link.core_data, blk);
            chk("core_key", link.core_key, key);
            chk("busy", link.busy, 1'b1);
         end
         if (n == 385) chk("start_one_cycle", link.core_start, 1'b0);
         if (n >= 389 && n <= 516) got[516-n] = link.sdo;
         if (n == 516) chk("frame_done_early", link.frame_done, 1'b0);
         if (n == 517) begin
            chk("frame_done", link.frame_done, 1'b1);
            chk("err_late", link.err_late, exp_late);
            chk("sdo_stream", got, exp_late ? 128'h0 : res);
         end
      end
   endtask

   initial begin
      link.cs     = 1'b1;
      link.sdi    = 1'b0;
      link.nk_val = 2'b00;
      repeat (3) @(negedge clk);
      chk("rst_busy", link.busy, 1'b0);
      chk("rst_sdo", link.sdo, 1'b0);
      chk("rst_core_data", link.core_data, 128'h0);
      chk("rst_err_late", link.err_late, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      // 128-bit key, then 256-bit key, each followed by deselect.
      run_frame(PT, KEY128, 2'b00, CT128, 2, 1'b0, 1'b1, 517);
      @(negedge clk);
      chk("idle_after_frame", link.busy, 1'b0);
      run_frame(PT, KEY256, 2'b10, CT256, 2, 1'b0, 1'b1, 517);

      // Abort after bit 200.
      @(negedge clk);
      for (int n = 0; n <= 200; n++) begin
         link.cs  = 1'b0;
         link.sdi = (n < 128) ? CT256[127-n] : 1'b1;
         @(negedge clk);
      end
      link.cs = 1'b1;
      @(negedge clk);
      chk("abort_busy", link.busy, 1'b0);
      chk("abort_partial_data", link.core_data, CT256);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | link.core_start;
      end
      chk("abort_no_start", seen, 1'b0);

      // Back-to-back frames, a late result, then recovery.
      run_frame(PT, KEY128, 2'b00, CT128, 2, 1'b0, 1'b0, 517);
      run_frame(PT, KEY256, 2'b10, CT256, 2, 1'b0, 1'b0, 517);
      run_frame(PT, KEY128, 2'b01, CT128, 10, 1'b1, 1'b0, 517);
      run_frame(PT, KEY128, 2'b00, CT128, 2, 1'b0, 1'b1, 517);

      // Asynchronous reset in the middle of TX.
      run_frame(PT, KEY256, 2'b10, CT256, 10, 1'b1, 1'b0, 450);
      #2 rst = 1'b1;
      #1;
      chk("arst_sdo", link.sdo, 1'b0);
      chk("arst_busy", link.busy, 1'b0);
      chk("arst_err_late", link.err_late, 1'b0);
      chk("arst_core_nk", link.core_nk, 2'b00);
      chk("arst_core_key", link.core_key, 256'h0);
      chk("arst_core_data", link.core_data, 128'h0);
      link.cs = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", link.busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
